// File: rtl/output_mem_writer.sv
// -----------------------------------------------------------------------------
// output_mem_writer
//
// Drains the skewed column outputs of a WIDTH_HEIGHT-wide systolic array into
// WIDTH_HEIGHT output memory banks. A drain writes N result rows per column.
// Column i lags column i-1 by one cycle, so column i writes row k during drain
// step cyc = i + k. Every output (write ports, busy, done) is registered, so
// everything appears one cycle after the step that produced it.
//
// Optional feature: define OUTPUT_MEM_WRITER_STALL_EN to add a 'stall' input.
// A stalled RUN cycle freezes the step counter and issues no writes. Without
// the macro the block behaves as if stall were tied low.
//
// Parameters
//   WIDTH_HEIGHT : number of array columns / output banks
//   ADDR_W       : per-bank address width
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   start      : one-cycle drain request, only honoured in IDLE
//   stall      : (OUTPUT_MEM_WRITER_STALL_EN only) pause the drain in RUN
//   base_addr  : first write address in every bank, captured with start
//   num_rows   : rows per column N, captured with start
//   col_data   : skewed column data, column i in bits [16i+15:16i]
//   wr_en      : per-bank write enable
//   wr_addr    : per-bank write address, bank i in slice i
//   wr_data    : per-bank write data, bank i in slice i
//   busy       : drain in progress
//   done       : one-cycle pulse at drain completion
// -----------------------------------------------------------------------------
module output_mem_writer #(
  parameter int WIDTH_HEIGHT = 4,
  parameter int ADDR_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
`ifdef OUTPUT_MEM_WRITER_STALL_EN
  input  logic                           stall,
`endif
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [7:0]                     num_rows,
  input  logic [WIDTH_HEIGHT*16-1:0]     col_data,
  output logic [WIDTH_HEIGHT-1:0]        wr_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
  output logic [WIDTH_HEIGHT*16-1:0]     wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int DATA_W = 16;
  // Wide enough for N + WIDTH_HEIGHT - 1 with N up to 255, plus headroom so
  // the counter running one past the last step never wraps to a live value.
  localparam int CYC_W  = 10 + $clog2(WIDTH_HEIGHT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                           state_q;
  state_t                           state_d;
  logic [CYC_W-1:0]                 cyc_q;
  logic [CYC_W-1:0]                 cyc_last;
  logic [ADDR_W-1:0]                base_q;
  logic [7:0]                       num_q;
  logic                             stall_w;
  logic                             advance;

  logic [WIDTH_HEIGHT-1:0]          vld_p0;
  logic [WIDTH_HEIGHT*ADDR_W-1:0]   addr_p0;

  logic [WIDTH_HEIGHT-1:0]          vld_p1;
  logic [WIDTH_HEIGHT*ADDR_W-1:0]   addr_p1;
  logic [WIDTH_HEIGHT*DATA_W-1:0]   data_p1;
  logic                             busy_p1;
  logic                             done_p1;

`ifdef OUTPUT_MEM_WRITER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Bank address for row k: silent modulo-2^ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CYC_W-1:0]  row_k);
    return base + ADDR_W'(row_k);
  endfunction

  // A RUN cycle that makes progress; stalled cycles neither count nor write.
  assign advance  = (state_q == RUN) && !stall_w;
  // Last drain step: column WIDTH_HEIGHT-1 writing row N-1.
  assign cyc_last = CYC_W'(num_q) + CYC_W'(WIDTH_HEIGHT) - CYC_W'(2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_rows == 8'd0) ? DONE : RUN;
      RUN:     if (advance && (cyc_q == cyc_last)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        base_q <= base_addr;
        num_q  <= num_rows;
        cyc_q  <= '0;
      end else if (advance) begin
        cyc_q  <= cyc_q + CYC_W'(1);
      end
    end
  end

  // ---- stage p0: per-column activity and address for the current step ----
  always_comb begin
    vld_p0  = '0;
    addr_p0 = '0;
    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
      // Column i is live for steps i .. i+N-1; its row index is cyc - i.
      vld_p0[i] = advance && (cyc_q >= CYC_W'(i)) &&
                  ((cyc_q - CYC_W'(i)) < CYC_W'(num_q));
      addr_p0[i*ADDR_W +: ADDR_W] = wrap_addr(base_q, cyc_q - CYC_W'(i));
    end
  end

  // ---- stage p1: registered write ports and status ----
  // Address and data only load on a write so idle banks hold their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      busy_p1 <= (state_q != IDLE);
      done_p1 <= (state_q == DONE);
      for (int i = 0; i < WIDTH_HEIGHT; i++) begin
        if (vld_p0[i]) begin
          addr_p1[i*ADDR_W +: ADDR_W] <= addr_p0[i*ADDR_W +: ADDR_W];
          data_p1[i*DATA_W +: DATA_W] <= col_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = data_p1;
  assign busy    = busy_p1;
  assign done    = done_p1;

endmodule

// File: tb/tb_output_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_output_mem_writer
//
// Scoreboard bench for output_mem_writer (WIDTH_HEIGHT=4, ADDR_W=8). Each drain
// issued by the stimulus side is expanded into the list of bank writes it must
// produce (cycle, bank, address, data), its done cycle and its busy window.
// A monitor sampling 1 time unit after every rising edge pops and compares.
// Column data for every cycle is pre-drawn at random so expected write data is
// known when the drain is issued.
// Cycle n is the interval after the n-th rising edge.
// -----------------------------------------------------------------------------
module tb_output_mem_writer;

  localparam int W    = 4;
  localparam int AW   = 8;
  localparam int MAXC = 2048;

  typedef struct {
    int          cyc;
    int          bank;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            start     = 1'b0;
  logic            stall     = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [7:0]      num_rows  = '0;
  logic [W*16-1:0] col_data;
  logic [W-1:0]    wr_en;
  logic [W*AW-1:0] wr_addr;
  logic [W*16-1:0] wr_data;
  logic            busy;
  logic            done;

  int              ecnt          = 0;
  int              checks        = 0;
  int              errors        = 0;
  int              last_done_cyc = -1;

  logic [W*16-1:0] col_mem [0:MAXC-1];
  bit              exp_busy [0:MAXC-1];
  wr_t             wq [$];
  int              dq [$];
  logic [7:0]      held_addr [0:W-1];
  logic [15:0]     held_data [0:W-1];

  output_mem_writer #(
    .WIDTH_HEIGHT (W),
    .ADDR_W       (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef OUTPUT_MEM_WRITER_STALL_EN
    .stall     (stall),
`endif
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .col_data  (col_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Present the pre-drawn column word that the next edge will sample.
  always @(negedge clk) begin
    if (ecnt + 1 < MAXC) col_data = col_mem[ecnt + 1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, ecnt, act, exp);
    end
  endtask

  // Expected behaviour of one drain whose start is sampled at edge s.
  // stall_e: first of two stalled edges (0 = none); rst_e: reset edge (0 = none).
  // Row k of column i is written at the (i+k+1)-th non-stalled edge after s,
  // to address base+k, with the column word sampled at that same edge.
  task automatic model_drain(input int s, input int base, input int n,
                             input int stall_e, input int rst_e, output int de);
    int  e;
    int  steps;
    wr_t w;
    if (n == 0) begin
      de = s + 1;
    end else begin
      steps = n + W - 1;
      e = s;
      for (int c = 0; c < steps; c++) begin
        e++;
        while (stall_e != 0 && e >= stall_e && e < stall_e + 2) e++;
        for (int i = 0; i < W; i++) begin
          if (c >= i && c - i < n && (rst_e == 0 || e < rst_e)) begin
            w.cyc  = e;
            w.bank = i;
            w.addr = 8'(base + c - i);
            w.data = col_mem[e][i*16 +: 16];
            wq.push_back(w);
          end
        end
      end
      de = e + 1;
    end
    if (rst_e != 0) begin
      for (int t = s + 1; t < rst_e; t++) exp_busy[t] = 1'b1;
      de = rst_e;
    end else begin
      for (int t = s + 1; t <= de; t++) exp_busy[t] = 1'b1;
      dq.push_back(de);
    end
  endtask

  // Called at a falling edge; the start is sampled at the next rising edge.
  // Returns at the falling edge of the drain's final cycle.
  task automatic run_drain(input int base, input int n, input bit second_start,
                           input int stall_off, input int rst_off, output int s);
    int de;
    s         = ecnt + 1;
    start     = 1'b1;
    base_addr = 8'(base);
    num_rows  = 8'(n);
    model_drain(s, base, n, (stall_off != 0) ? s + stall_off : 0,
                (rst_off != 0) ? s + rst_off : 0, de);
    @(negedge clk);
    start = 1'b0;
    while (ecnt < de) begin
      base_addr = 8'($urandom);
      num_rows  = 8'($urandom);
      start     = 1'b0;
      if (second_start && (ecnt + 1 == s + 3)) begin
        start     = 1'b1;
        num_rows  = 8'd5;
        base_addr = 8'(base + 8'h33);
      end
      stall = (stall_off != 0) && (ecnt + 1 >= s + stall_off) && (ecnt + 1 < s + stall_off + 2);
      reset = (rst_off != 0) && (ecnt + 1 == s + rst_off);
      @(negedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: compare everything the DUT presents against the scoreboard.
  initial begin
    for (int i = 0; i < W; i++) begin
      held_addr[i] = '0;
      held_data[i] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("rst_wr_en",   64'(wr_en),   64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        for (int i = 0; i < W; i++) begin
          held_addr[i] = '0;
          held_data[i] = '0;
        end
      end else begin
        check("busy", 64'(busy), 64'(exp_busy[ecnt]));
        while (wq.size() > 0 && wq[0].cyc < ecnt) begin
          check("write_missing_bank", 64'(0), 64'(1));
          void'(wq.pop_front());
        end
        for (int i = 0; i < W; i++) begin
          if (wr_en[i]) begin
            if (wq.size() > 0 && wq[0].cyc == ecnt && wq[0].bank == i) begin
              check("wr_addr", 64'(wr_addr[i*AW +: AW]), 64'(wq[0].addr));
              check("wr_data", 64'(wr_data[i*16 +: 16]), 64'(wq[0].data));
              held_addr[i] = wq[0].addr;
              held_data[i] = wq[0].data;
              void'(wq.pop_front());
            end else begin
              check("wr_en_unexpected", 64'(i + 1), 64'(0));
            end
          end else begin
            if (wq.size() > 0 && wq[0].cyc == ecnt && wq[0].bank == i) begin
              check("wr_en_missing", 64'(0), 64'(i + 1));
              void'(wq.pop_front());
            end
            check("hold_addr", 64'(wr_addr[i*AW +: AW]), 64'(held_addr[i]));
            check("hold_data", 64'(wr_data[i*16 +: 16]), 64'(held_data[i]));
          end
        end
        if (done) begin
          last_done_cyc = ecnt;
          if (dq.size() > 0 && dq[0] == ecnt) begin
            check("done_cycle", 64'(ecnt), 64'(dq[0]));
            void'(dq.pop_front());
          end else begin
            check("done_unexpected", 64'(1), 64'(0));
          end
        end else if (dq.size() > 0 && dq[0] <= ecnt) begin
          check("done_missing", 64'(0), 64'(1));
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    int s;
    int n;
    for (int c = 0; c < MAXC; c++) begin
      col_mem[c]  = {$urandom, $urandom};
      exp_busy[c] = 1'b0;
    end
    col_data = col_mem[1];

    // Reset held across three edges.
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic drain: base 0x10, N=3 -> done 7 cycles after the start edge.
    run_drain(8'h10, 3, 1'b0, 0, 0, s);
    check("basic_done_latency", 64'(last_done_cyc - s), 64'd7);

    // Address wrap: FE, FF, 00, 01 in every bank.
    run_drain(8'hFE, 4, 1'b0, 0, 0, s);
    check("wrap_done_latency", 64'(last_done_cyc - s), 64'd8);

    // Zero rows: no writes, one busy cycle, done on the next cycle.
    run_drain(8'h55, 0, 1'b0, 0, 0, s);
    check("zero_done_latency", 64'(last_done_cyc - s), 64'd1);

    // A second start (N=5) mid-drain is ignored; the drain keeps N=3.
    run_drain(8'h40, 3, 1'b1, 0, 0, s);
    check("busy_start_done_latency", 64'(last_done_cyc - s), 64'd7);

    // Reset at cycle 2 of an N=8 drain: writes stop, no done pulse.
    run_drain(8'h80, 8, 1'b0, 0, 2, s);
    check("reset_no_done", 64'(last_done_cyc < s), 64'd1);

    // IDLE reached after the abort: a new drain starts straight away.
    run_drain(8'h90, 2, 1'b0, 0, 0, s);
    check("post_reset_done_latency", 64'(last_done_cyc - s), 64'd6);

`ifdef OUTPUT_MEM_WRITER_STALL_EN
    // Two stalled cycles at cyc=1 push the pattern and done back by 2.
    run_drain(8'h20, 3, 1'b0, 2, 0, s);
    check("stall_done_latency", 64'(last_done_cyc - s), 64'd9);
`endif

    // Randomized drains, including back-to-back starts and ignored restarts.
    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n = $urandom_range(0, 9);
      run_drain($urandom_range(0, 255), n, (n >= 2) && ($urandom_range(0, 1) == 1), 0, 0, s);
      check("rand_done_latency", 64'(last_done_cyc - s), 64'((n == 0) ? 1 : n + W));
    end

    repeat (4) @(negedge clk);
    check("writes_outstanding", 64'(wq.size()), 64'd0);
    check("done_outstanding",   64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_mem_writer.md
OUTPUT_MEM_WRITER -- requirements
Module: output_mem_writer

Interface
REQ-001 SHALL have parameter WIDTH_HEIGHT, default 4, giving the number of array columns and output memory banks.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the per-bank address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a drain; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first write address in every bank, sampled with start.
REQ-007 SHALL have port num_rows, input, 8 bits: result rows per column (N), sampled with start.
REQ-008 SHALL have port col_data, input, WIDTH_HEIGHT*16 bits: skewed array outputs; column i occupies bits [16i+15:16i].
REQ-009 SHALL have port wr_en, output, WIDTH_HEIGHT bits: per-bank write enable.
REQ-010 SHALL have port wr_addr, output, WIDTH_HEIGHT*ADDR_W bits: per-bank write address, bank i in slice i.
REQ-011 SHALL have port wr_data, output, WIDTH_HEIGHT*16 bits: per-bank write data.
REQ-012 SHALL have port busy, output, 1 bit: high while a drain is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at drain completion.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE to RUN on start when N>0.
- IDLE to DONE on start when N=0; no writes are issued.
- RUN to DONE after cycle counter cyc reaches N+WIDTH_HEIGHT-2.
- DONE to IDLE unconditionally after one cycle.
REQ-015 SHALL clear cyc to 0 on entry to RUN and increment it by 1 each RUN cycle.
REQ-016 SHALL treat column i as active in a RUN cycle when i <= cyc < i+N, with row index k = cyc-i.
REQ-017 SHALL register the write outputs with one cycle of latency.
- wr_en[i] is high exactly i+k+1 cycles after the start-sampling edge, for k=0..N-1, and low otherwise.
- wr_addr slice i = (base_addr + k) mod 2^ADDR_W, wrapping silently.
- wr_data slice i = col_data slice i as sampled in the cycle before.
REQ-018 SHALL hold wr_addr and wr_data at their last values while the matching wr_en bit is low.
REQ-019 SHALL drive busy high in RUN and DONE and low in IDLE.
REQ-020 SHALL assert done for exactly the single cycle spent in DONE.
REQ-021 SHALL ignore start while busy; base_addr and num_rows captures are unaffected.
REQ-022 SHALL accept a start in the first IDLE cycle after DONE (back-to-back drains).
REQ-023 SHALL NOT let the latched parameters change during a drain when the base_addr or num_rows inputs change.

Reset
REQ-024 SHALL, on reset, force state IDLE and clear cyc and the latched base/N to 0.
REQ-025 SHALL, on reset, drive wr_en=0, wr_addr=0, wr_data=0, busy=0 and done=0 from the next edge.
REQ-026 SHALL let reset override start when both are asserted in the same cycle.
REQ-027 SHALL, on reset during RUN, abort the drain with no further writes and no done pulse.

Configuration
REQ-028 SHALL, when macro OUTPUT_MEM_WRITER_STALL_EN is defined, add input port stall (1 bit).
- While stall is high in RUN: cyc holds, all wr_en bits are 0 in the following cycle, and no transition occurs.
- When stall deasserts, the drain resumes exactly where it left off with the same column skew.
- stall has no effect in IDLE or DONE.
REQ-029 SHALL, when OUTPUT_MEM_WRITER_STALL_EN is undefined, have no stall port and behave as if stall were 0.

Verification
REQ-030 Bench SHALL cover a basic drain: W=4, base=0x10, N=3, start at edge 0.
- wr_en[0] is high at cycles 1-3 and wr_en[3] at cycles 4-6.
- Addresses are 0x10, 0x11, 0x12 per bank.
- done pulses at cycle 7.
REQ-031 Bench SHALL cover address wrap: base=0xFE, N=4 -> each bank writes addresses FE, FF, 00, 01.
REQ-032 Bench SHALL cover zero rows: N=0 -> no wr_en bit is ever high, busy is high for one cycle, and done pulses at cycle 1.
REQ-033 Bench SHALL cover start while busy: a second start in mid-RUN with N=5 -> ignored; the drain completes with the original N=3.
REQ-034 Bench SHALL cover reset at cycle 2 of an N=8 drain -> wr_en=0 from the next edge, no done pulse, and IDLE entered.
REQ-035 Bench SHALL cover stall (OUTPUT_MEM_WRITER_STALL_EN only): stall high for 2 cycles at cyc=1 -> the write pattern shifts by 2 cycles with addresses unchanged and done delayed by 2.
